// File: rtl/mul_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_iter_ctrl
// Purpose  : Sequencer for a shared iterative shift-add multiplier that runs
//            mul/mulh/mulhu and returns a one-cycle register-file writeback.
// Revision : 1.0
// ============================================================================
module mul_iter_ctrl #(
    parameter int         XLEN     = 32,
    parameter logic [3:0] OP_MUL   = 4'b0101,
    parameter logic [3:0] OP_MULH  = 4'b0110,
    parameter logic [3:0] OP_MULHU = 4'b0111
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      instr,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int                CW       = $clog2(XLEN);
    localparam logic [CW-1:0]     C_LAST   = CW'(XLEN - 1);
    localparam logic [CW-1:0]     C_CNT1   = CW'(1);
    localparam logic [XLEN-1:0]   C_ONE    = XLEN'(1);
    localparam logic [2*XLEN-1:0] C_ONE2   = (2*XLEN)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_op;
    logic              r_neg;
    logic [2*XLEN-1:0] r_p;
    logic [XLEN-1:0]   r_m;
    logic [CW-1:0]     r_cnt;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_out;

    logic              w_valid_op;
    logic              w_accept;
    logic              w_signed;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_p_fix;

    assign w_valid_op = (instr == OP_MUL) || (instr == OP_MULH) || (instr == OP_MULHU);
    // flush in IDLE wins over a new request
    assign w_accept   = (r_state == S_IDLE) && start && w_valid_op && !flush;
    assign w_signed   = (instr == OP_MULH);
    assign w_a_abs    = (w_signed && a[XLEN-1]) ? (~a + C_ONE) : a;
    assign w_b_abs    = (w_signed && b[XLEN-1]) ? (~b + C_ONE) : b;
    assign w_sum      = r_p[0] ? ({1'b0, r_p[2*XLEN-1:XLEN]} + {1'b0, r_m})
                               : {1'b0, r_p[2*XLEN-1:XLEN]};
    assign w_p_fix    = r_neg ? (~r_p + C_ONE2) : r_p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_p      <= '0;
            r_m      <= '0;
            r_cnt    <= '0;
            r_rd     <= '0;
            r_result <= '0;
            r_rd_out <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= instr;
                        r_neg <= w_signed && (a[XLEN-1] ^ b[XLEN-1]);
                        r_p   <= {{XLEN{1'b0}}, w_b_abs};
                        r_m   <= w_a_abs;
                        r_cnt <= '0;
                        r_rd  <= rd_in;
                    end
                end
                S_RUN: begin
                    r_p   <= {w_sum, r_p[XLEN-1:1]};
                    r_cnt <= r_cnt + C_CNT1;
                end
                S_FIX: begin
                    if (!flush) begin
                        r_result <= (r_op == OP_MUL) ? w_p_fix[XLEN-1:0]
                                                     : w_p_fix[2*XLEN-1:XLEN];
                        r_rd_out <= r_rd;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = w_accept;
                if (w_accept) w_next = S_RUN;
            end
            S_RUN: begin
                stall = 1'b1;
                if (flush)                w_next = S_IDLE;
                else if (r_cnt == C_LAST) w_next = S_FIX;
            end
            S_FIX: begin
                stall  = 1'b1;
                w_next = flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done   = !flush;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign result = r_result;
    assign rd_out = r_rd_out;

endmodule
`default_nettype wire

// File: tb/tb_mul_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_iter_ctrl
// Purpose  : Scoreboarded random/directed bench for mul_iter_ctrl.
// Revision : 1.0
// ============================================================================
module tb_mul_iter_ctrl;

    localparam logic [3:0] OP_MUL   = 4'b0101;
    localparam logic [3:0] OP_MULH  = 4'b0110;
    localparam logic [3:0] OP_MULHU = 4'b0111;
    localparam int         LAT      = 34;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  instr = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  rd_in = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic e_stall = 1'b0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          at;
    } exp_t;
    exp_t sb[$];

    mul_iter_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .instr  (instr),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] ref_mul(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ex, ey, p;
        if (op == OP_MULH) begin
            ex = {{32{x[31]}}, x};
            ey = {{32{y[31]}}, y};
        end else begin
            ex = {32'b0, x};
            ey = {32'b0, y};
        end
        p = ex * ey;
        return (op == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: compares writebacks against the scoreboard and stall against its expectation
    always @(negedge clk) begin
        if (!rst) begin
            check("stall", {31'b0, stall}, {31'b0, e_stall});
            while (sb.size() > 0 && sb[0].at < cyc) begin
                check("done_missing", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
            if (done) begin
                if (sb.size() == 0 || sb[0].at != cyc) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    check("result", result, sb[0].res);
                    check("rd_out", {27'b0, rd_out}, {27'b0, sb[0].rd});
                    void'(sb.pop_front());
                end
            end else if (sb.size() > 0 && sb[0].at == cyc) begin
                check("done_missing", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_done"},   {31'b0, done},   32'd0);
        check({tag, "_stall"},  {31'b0, stall},  32'd0);
        check({tag, "_result"}, result,          32'd0);
        check({tag, "_rd_out"}, {27'b0, rd_out}, 32'd0);
    endtask

    // mode: 0 normal, 1 flush at RUN cycle k, 2 flush in DONE, 3 flush with start in IDLE, 4 rst at RUN cycle k
    task automatic do_op(input logic [3:0] ins, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [4:0] rdd, input int mode, input int k);
        bit   valid;
        exp_t e;
        valid = (ins == OP_MUL) || (ins == OP_MULH) || (ins == OP_MULHU);
        step();
        start = 1'b1; instr = ins; a = aa; b = bb; rd_in = rdd;
        flush = (mode == 3);
        e_stall = valid && (mode != 3);
        if (!(valid && mode != 3)) begin
            step();
            start = 1'b0; flush = 1'b0; e_stall = 1'b0;
            return;
        end
        if (mode == 0) begin
            e.res = ref_mul(ins, aa, bb);
            e.rd  = rdd;
            e.at  = cyc + LAT;
            sb.push_back(e);
        end
        for (int i = 0; i < 32; i++) begin
            step();
            start = 1'b0; flush = 1'b0; e_stall = 1'b1;
            if (i == 5) begin
                start = 1'b1; instr = OP_MUL; a = 32'd9; b = 32'd9; rd_in = 5'($urandom);
            end
            if (mode == 1 && i == k) begin
                flush = 1'b1;
                step();
                start = 1'b0; flush = 1'b0; e_stall = 1'b0;
                return;
            end
            if (mode == 4 && i == k) begin
                start = 1'b0; rst = 1'b1; e_stall = 1'b0;
                #1;
                check_zero("rst_mid");
                step();
                rst = 1'b0;
                return;
            end
        end
        step();
        start = 1'b0; e_stall = 1'b1;
        step();
        e_stall = 1'b0;
        flush = (mode == 2);
        step();
        flush = 1'b0;
    endtask

    initial begin
        logic [3:0]  ops [3];
        logic [31:0] specials [6];
        logic [31:0] ra, rb;
        int          r, mode, k;
        ops[0] = OP_MUL; ops[1] = OP_MULH; ops[2] = OP_MULHU;
        specials[0] = 32'h0;        specials[1] = 32'h1;
        specials[2] = 32'hFFFFFFFF; specials[3] = 32'h80000000;
        specials[4] = 32'h7FFFFFFF; specials[5] = 32'h2;

        #2;
        check_zero("reset");
        step();
        rst = 1'b0;

        do_op(OP_MUL,   32'd7,        32'd6,        5'd5,  0, 0);
        do_op(OP_MULH,  32'hFFFFFFFF, 32'h2,        5'd1,  0, 0);
        do_op(OP_MUL,   32'hFFFFFFFF, 32'h2,        5'd2,  0, 0);
        do_op(OP_MULHU, 32'hFFFFFFFF, 32'h2,        5'd3,  0, 0);
        do_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  0, 0);
        do_op(OP_MULH,  32'h80000000, 32'h80000000, 5'd6,  0, 0);
        do_op(OP_MULH,  32'h80000000, 32'h1,        5'd7,  0, 0);
        do_op(4'b0011,  32'd5,        32'd5,        5'd8,  0, 0);
        do_op(OP_MUL,   32'd0,        32'd12345,    5'd9,  0, 0);
        do_op(OP_MUL,   32'd100,      32'd200,      5'd10, 4, 10);
        do_op(OP_MUL,   32'd3,        32'd4,        5'd11, 0, 0);
        do_op(OP_MUL,   32'd55,       32'd66,       5'd12, 1, 20);
        do_op(OP_MULHU, 32'd77,       32'd88,       5'd13, 2, 0);
        do_op(OP_MUL,   32'd13,       32'd17,       5'd14, 3, 0);
        do_op(OP_MULH,  32'hFFFFFFF9, 32'd6,        5'd15, 0, 0);

        for (int n = 0; n < 120; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            r  = $urandom_range(0, 19);
            mode = (r < 13) ? 0 : (r < 15) ? 1 : (r < 17) ? 2 : (r < 19) ? 3 : 4;
            k  = $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0)
                do_op(4'($urandom_range(8, 15)), ra, rb, 5'($urandom), 0, 0);
            else
                do_op(ops[$urandom_range(0, 2)], ra, rb, 5'($urandom), mode, k);
        end

        repeat (3) step();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog at cycle %0d: got timeout, expected completion", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
